// File: rtl/mc_ramp_controller.sv
// Multi-channel motor-command slew limiter: ramps each channel one power step per tick toward its
// desired command, forcing brake -> neutral -> dwell on direction changes, with a global E-stop.
`timescale 1ns/1ps

module mc_ramp_controller #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PWR_W       = 3,
    parameter int unsigned TICK_CYCLES = 8800000,
    parameter int unsigned DWELL_TICKS = 2,
    parameter int unsigned ESTOP_STEP  = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_CH*(PWR_W+2)-1:0]  DESIRED_MC,
    input  logic                         ESTOP,
    output logic [NUM_CH*(PWR_W+2)-1:0]  MCP,
    output logic [NUM_CH-1:0]            SETTLED,
    output logic                         TICK
);

    localparam int unsigned MC_W  = PWR_W + 2;
    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DW_W  = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;

    localparam logic [1:0] DIR_A       = 2'b00;
    localparam logic [1:0] DIR_NEUTRAL = 2'b01;
    localparam logic [1:0] DIR_B       = 2'b10;

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_BRAKE   = 2'd2
    } ch_state_e;

    // Unsigned subtraction clamped at zero.
    function automatic logic [PWR_W-1:0] sat_sub(input logic [PWR_W-1:0] a, input int unsigned b);
        if (32'(a) > b) return a - PWR_W'(b);
        else            return '0;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_W'(TICK_CYCLES - 1));
    assign TICK   = w_tick;

    // Free-running tick prescaler shared by all channels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + CNT_W'(1);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_state_e        r_state, w_nxt_state;
        logic [PWR_W-1:0] r_pwr, w_nxt_pwr;
        logic [1:0]       r_dir, w_nxt_dir;
        logic [DW_W-1:0]  r_dwell, w_nxt_dwell;

        logic [PWR_W-1:0] w_des_pwr, w_eff_pwr, w_dec_pwr;
        logic [1:0]       w_des_dir, w_eff_dir;
        logic             w_eff_neutral;

        assign w_des_pwr     = DESIRED_MC[k*MC_W+2 +: PWR_W];
        assign w_des_dir     = DESIRED_MC[k*MC_W   +: 2];
        // Dir codes 01 and 11 both have bit 0 set, so bit 0 alone flags a neutral request.
        assign w_eff_neutral = ESTOP | w_des_dir[0];
        assign w_eff_pwr     = w_eff_neutral ? '0 : w_des_pwr;
        assign w_eff_dir     = w_eff_neutral ? DIR_NEUTRAL : w_des_dir;
        assign w_dec_pwr     = ESTOP ? sat_sub(r_pwr, ESTOP_STEP) : sat_sub(r_pwr, 1);

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_state <= ST_NEUTRAL;
                r_pwr   <= '0;
                r_dir   <= DIR_NEUTRAL;
                r_dwell <= '0;
            end else begin
                r_state <= w_nxt_state;
                r_pwr   <= w_nxt_pwr;
                r_dir   <= w_nxt_dir;
                r_dwell <= w_nxt_dwell;
            end
        end

        always_comb begin
            w_nxt_state = r_state;
            w_nxt_pwr   = r_pwr;
            w_nxt_dir   = r_dir;
            w_nxt_dwell = r_dwell;
            if (w_tick) begin
                case (r_state)
                    ST_NEUTRAL: begin
                        w_nxt_pwr = '0;
                        w_nxt_dir = DIR_NEUTRAL;
                        if (r_dwell != '0) begin
                            w_nxt_dwell = r_dwell - DW_W'(1);
                        end else if (w_eff_dir == DIR_A || w_eff_dir == DIR_B) begin
                            w_nxt_state = ST_DRIVE;
                            w_nxt_dir   = w_eff_dir;
                        end
                    end
                    ST_DRIVE: begin
                        // E-stop decays power in place so the ramp resumes if it clears early.
                        if (ESTOP || w_eff_dir != r_dir) begin
                            if (r_pwr != '0) begin
                                w_nxt_pwr = w_dec_pwr;
                                if (!ESTOP) w_nxt_state = ST_BRAKE;
                            end else if (ESTOP) begin
                                w_nxt_state = ST_NEUTRAL;
                                w_nxt_dir   = DIR_NEUTRAL;
                                w_nxt_dwell = DW_W'(DWELL_TICKS);
                            end else begin
                                w_nxt_state = ST_BRAKE;
                            end
                        end else if (r_pwr < w_eff_pwr) begin
                            w_nxt_pwr = r_pwr + PWR_W'(1);
                        end else if (r_pwr > w_eff_pwr) begin
                            w_nxt_pwr = r_pwr - PWR_W'(1);
                        end
                    end
                    ST_BRAKE: begin
                        if (r_pwr != '0) begin
                            w_nxt_pwr = w_dec_pwr;
                        end else begin
                            w_nxt_state = ST_NEUTRAL;
                            w_nxt_dir   = DIR_NEUTRAL;
                            w_nxt_dwell = DW_W'(DWELL_TICKS);
                        end
                    end
                    default: begin
                        w_nxt_state = ST_NEUTRAL;
                        w_nxt_pwr   = '0;
                        w_nxt_dir   = DIR_NEUTRAL;
                        w_nxt_dwell = '0;
                    end
                endcase
            end
        end

        assign MCP[k*MC_W +: MC_W] = {r_pwr, r_dir};
        assign SETTLED[k]          = ({r_pwr, r_dir} == {w_eff_pwr, w_eff_dir});
    end

endmodule

// File: tb/tb_mc_ramp_controller.sv
// Directed bench for mc_ramp_controller with a 4-cycle tick, 3-bit power and two channels.
`timescale 1ns/1ps

module tb_mc_ramp_controller;

    logic       CLK;
    logic       RST_N;
    logic [9:0] DESIRED_MC;
    logic       ESTOP;
    logic [9:0] MCP;
    logic [1:0] SETTLED;
    logic       TICK;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [4:0] NEU = {3'd0, 2'b01};

    mc_ramp_controller #(
        .NUM_CH(2), .PWR_W(3), .TICK_CYCLES(4), .DWELL_TICKS(2), .ESTOP_STEP(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .DESIRED_MC(DESIRED_MC), .ESTOP(ESTOP),
        .MCP(MCP), .SETTLED(SETTLED), .TICK(TICK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to the negedge following the next channel update edge.
    task automatic tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge CLK);
            if (TICK === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL tick_timeout: TICK never seen within 16 cycles");
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N      = 1'b0;
        ESTOP      = 1'b0;
        DESIRED_MC = {NEU, NEU};
        repeat (3) @(negedge CLK);
        n_vec++;
        if (MCP !== {NEU, NEU}) begin
            n_err++; $display("FAIL reset_mcp: got %b expected %b", MCP, {NEU, NEU});
        end
        n_vec++;
        if (TICK !== 1'b0) begin
            n_err++; $display("FAIL reset_tick: got %b expected 0", TICK);
        end
        n_vec++;
        if (SETTLED !== 2'b11) begin
            n_err++; $display("FAIL reset_settled: got %b expected 11", SETTLED);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_ramp_up();
        logic [4:0] exp_w;
        DESIRED_MC = {NEU, 3'd5, 2'b10};
        #1;
        n_vec++;
        if (MCP[4:0] !== NEU || SETTLED[0] !== 1'b0) begin
            n_err++; $display("FAIL ramp_pre_tick: got mcp %b settled %b expected %b/0", MCP[4:0], SETTLED[0], NEU);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_w = {3'(i), 2'b10};
            n_vec++;
            if (MCP[4:0] !== exp_w || SETTLED[0] !== (i == 5)) begin
                n_err++;
                $display("FAIL ramp_up[%0d]: got mcp %b settled %b expected %b/%b", i, MCP[4:0], SETTLED[0], exp_w, (i == 5));
            end
        end
        n_vec++;
        if (MCP[9:5] !== NEU || SETTLED[1] !== 1'b1) begin
            n_err++; $display("FAIL ramp_ch1_idle: got %b/%b expected %b/1", MCP[9:5], SETTLED[1], NEU);
        end
    endtask

    task automatic test_dir_change();
        logic [4:0] exp_t [12] = '{
            {3'd4, 2'b10}, {3'd3, 2'b10}, {3'd2, 2'b10}, {3'd1, 2'b10}, {3'd0, 2'b10},
            NEU, NEU, NEU,
            {3'd0, 2'b00}, {3'd1, 2'b00}, {3'd2, 2'b00}, {3'd3, 2'b00}};
        DESIRED_MC = {NEU, 3'd3, 2'b00};
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (MCP[4:0] !== exp_t[i]) begin
                n_err++; $display("FAIL dir_change[%0d]: got %b expected %b", i, MCP[4:0], exp_t[i]);
            end
        end
        n_vec++;
        if (SETTLED[0] !== 1'b1) begin
            n_err++; $display("FAIL dir_change_settled: got %b expected 1", SETTLED[0]);
        end
        DESIRED_MC = {NEU, 3'd7, 2'b00};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (MCP[4:0] !== {3'(4 + i), 2'b00}) begin
                n_err++; $display("FAIL climb_to_7[%0d]: got %b expected %b", i, MCP[4:0], {3'(4 + i), 2'b00});
            end
        end
    endtask

    task automatic test_estop_pulse();
        logic [2:0] exp_p [6] = '{3'd5, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ESTOP = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) begin
                n_vec++;
                if (SETTLED !== 2'b10) begin
                    n_err++; $display("FAIL estop_pulse_settled: got %b expected 10", SETTLED);
                end
                ESTOP = 1'b0;
            end
            n_vec++;
            if (MCP[4:0] !== {exp_p[i], 2'b00}) begin
                n_err++; $display("FAIL estop_pulse[%0d]: got %b expected %b", i, MCP[4:0], {exp_p[i], 2'b00});
            end
        end
    endtask

    task automatic test_estop_hold();
        logic [4:0] exp_t [5] = '{{3'd5, 2'b00}, {3'd3, 2'b00}, {3'd1, 2'b00}, {3'd0, 2'b00}, NEU};
        ESTOP = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (MCP[4:0] !== exp_t[i]) begin
                n_err++; $display("FAIL estop_hold[%0d]: got %b expected %b", i, MCP[4:0], exp_t[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (MCP[4:0] !== NEU || SETTLED[0] !== 1'b1) begin
                n_err++; $display("FAIL estop_no_engage[%0d]: got %b/%b expected %b/1", i, MCP[4:0], SETTLED[0], NEU);
            end
        end
        ESTOP = 1'b0;
        tick();
        n_vec++;
        if (MCP[4:0] !== {3'd0, 2'b00}) begin
            n_err++; $display("FAIL estop_release: got %b expected %b", MCP[4:0], {3'd0, 2'b00});
        end
    endtask

    task automatic test_invalid_dir();
        DESIRED_MC = {3'd6, 2'b11, 3'd6, 2'b11};
        #1;
        n_vec++;
        if (SETTLED !== 2'b10) begin
            n_err++; $display("FAIL invalid_dir_settled_now: got %b expected 10", SETTLED);
        end
        tick();
        n_vec++;
        if (MCP !== {NEU, 3'd0, 2'b00}) begin
            n_err++; $display("FAIL invalid_dir_brake: got %b expected %b", MCP, {NEU, 3'd0, 2'b00});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (MCP !== {NEU, NEU} || SETTLED !== 2'b11) begin
                n_err++; $display("FAIL invalid_dir_neutral[%0d]: got %b/%b expected %b/11", i, MCP, SETTLED, {NEU, NEU});
            end
        end
    endtask

    task automatic test_async_reset();
        DESIRED_MC = {3'd4, 2'b10, NEU};
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (MCP[9:5] !== {3'd4, 2'b10}) begin
            n_err++; $display("FAIL pre_reset_ch1: got %b expected %b", MCP[9:5], {3'd4, 2'b10});
        end
        #2 RST_N = 1'b0;
        #0.5;
        n_vec++;
        if (MCP !== {NEU, NEU} || TICK !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got mcp %b tick %b expected %b/0", MCP, TICK, {NEU, NEU});
        end
        #0.5 RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            n_vec++;
            if (TICK !== ((i % 4) == 2)) begin
                n_err++; $display("FAIL tick_period[%0d]: got %b expected %b", i, TICK, ((i % 4) == 2));
            end
            if (i == 3) begin
                n_vec++;
                if (MCP[9:5] !== {3'd0, 2'b10}) begin
                    n_err++; $display("FAIL post_reset_ch1: got %b expected %b", MCP[9:5], {3'd0, 2'b10});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_dir_change();
        test_estop_pulse();
        test_estop_hold();
        test_invalid_dir();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
